load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// The decoder reuses lsu_fault() so both sides agree on what traps.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Alignment or width fault for a memory op at byte offset off.
    function automatic logic lsu_fault(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic f;
        f = 1'b0;
        if (f3[1:0] == 2'b11)                    f = 1'b1;
        if (we && f3[2])                         f = 1'b1;
        if ((f3[1:0] == 2'b01) && off[0])        f = 1'b1;
        if ((f3[1:0] == 2'b10) && (off != 2'b00)) f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication + byte enables, and load lane
// select with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [NUM_LANES-1:0][7:0] lanes;
    logic [31:0]               shifted;

    // Replicate the narrow datum so every lane carries it; be picks the lane.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            unique case (st_f3[1:0])
                2'b00:   lanes[i] = st_data[7:0];
                2'b01:   lanes[i] = st_data[8*(i%2) +: 8];
                default: lanes[i] = st_data[8*i +: 8];
            endcase
        end
    end

    assign wdata = lanes;

    always_comb begin
        be = 4'b1111;
        if (st_we) begin
            unique case (st_f3[1:0])
                2'b00:   be = 4'b0001 << st_off;
                2'b01:   be = st_off[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
    end

    assign shifted = rdata >> {ld_off, 3'b000};

    always_comb begin
        unique case (ld_f3)
            F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ldata = {24'h0, shifted[7:0]};
            F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ldata = {16'h0, shifted[15:0]};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/gnt/rvalid bus transaction per memory op,
// stalling the core from accept until the DONE cycle retires it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluresult,
    input  logic [31:0] rs2_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          op, fault, accept, tmo;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic [31:0]   al_wdata, al_ldata;
    logic [3:0]    al_be;

    assign op    = mem_read | mem_write;
    assign fault = lsu_fault(mem_write, funct3, aluresult[1:0]);
    // cnt holds cycles already spent in REQ+WAIT; this is the last allowed one.
    assign tmo   = (cnt == CW'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .st_we   (mem_write),
        .st_f3   (funct3),
        .st_off  (aluresult[1:0]),
        .st_data (rs2_data),
        .wdata   (al_wdata),
        .be      (al_be),
        .ld_f3   (f3_q),
        .ld_off  (off_q),
        .rdata   (dbus_rdata),
        .ldata   (al_ldata)
    );

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (op && !reset) begin
                    if (fault) begin
                        misaligned = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (tmo)           state_nxt = DONE;
                else if (dbus_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dbus_rvalid || tmo) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_wdata <= 32'h0;
            dbus_be    <= 4'h0;
            load_data  <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        off_q      <= aluresult[1:0];
                        f3_q       <= funct3;
                        we_q       <= mem_write;
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_write;
                        dbus_addr  <= {aluresult[31:2], 2'b00};
                        dbus_wdata <= al_wdata;
                        dbus_be    <= al_be;
                        load_data  <= 32'h0;
                        bus_err    <= 1'b0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (tmo) begin
                        dbus_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end else if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (dbus_rvalid) begin
                        load_data <= we_q ? 32'h0 : al_ldata;
                    end else if (tmo) begin
                        bus_err   <= 1'b1;
                        load_data <= 32'h0;
                    end
                end
                DONE: begin
                    // Result was consumed on this edge; keep IDLE outputs clean.
                    load_data <= 32'h0;
                    bus_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus/result records are
// queued as each access is driven and checked when the access retires.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] aluresult = 32'h0, rs2_data = 32'h0;
    logic        stall, misaligned, bus_err;
    logic [31:0] load_data;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .aluresult(aluresult), .rs2_data(rs2_data),
        .stall(stall), .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        int          cycles;
    } exp_t;

    typedef struct {
        logic        stall0, stall_mid, stable, req, we, done, err, req_done;
        logic [31:0] addr, wdata, ld;
        logic [3:0]  be;
        int          cycles;
    } obs_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*off +: 8];
        h = rd[16*off[1] +: 16];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic void m_store(input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] d, output logic [31:0] w,
                                    output logic [3:0] be);
        case (f3[1:0])
            2'b00: begin
                w = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (off)
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
            end
            2'b01: begin
                w  = {d[15:0], d[15:0]};
                be = (off >= 2'd2) ? 4'b1100 : 4'b0011;
            end
            default: begin
                w  = d;
                be = 4'b1111;
            end
        endcase
    endfunction

    // Runs one access; gnt after gdly cycles, rvalid after rdly more (or never).
    task automatic drive_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data, input int gdly, input int rdly,
                                input logic give_rv, input logic [31:0] rdata, output obs_t o);
        mem_write = we; mem_read = !we; funct3 = f3; aluresult = addr; rs2_data = data;
        #1;
        o.stall0 = stall; o.stall_mid = 1'b1; o.stable = 1'b1; o.cycles = 0;
        @(posedge clk); #1; o.cycles++;
        o.req = dbus_req; o.addr = dbus_addr; o.we = dbus_we; o.be = dbus_be; o.wdata = dbus_wdata;
        for (int k = 0; k <= gdly; k++) begin
            if (k == gdly) dbus_gnt = 1'b1;
            o.stall_mid &= stall;
            o.stable &= (dbus_req == 1'b1) && (dbus_addr == o.addr) && (dbus_wdata == o.wdata)
                        && (dbus_be == o.be) && (dbus_we == o.we);
            @(posedge clk); #1; o.cycles++;
        end
        dbus_gnt = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            o.stall_mid &= stall;
            @(posedge clk); #1; o.cycles++;
        end
        if (give_rv) begin
            dbus_rvalid = 1'b1; dbus_rdata = rdata;
            o.stall_mid &= stall;
            @(posedge clk); #1; o.cycles++;
            dbus_rvalid = 1'b0;
        end else begin
            while (stall && o.cycles < 200) begin
                @(posedge clk); #1; o.cycles++;
            end
        end
        o.done = !stall; o.ld = load_data; o.err = bus_err; o.req_done = dbus_req;
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({stall, misaligned, bus_err, dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, load_data} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got stall=%b req=%b addr=%h ld=%h, want all 0",
                              stall, dbus_req, dbus_addr, load_data);
        end
        mem_read = 1'b1; funct3 = F3_W; aluresult = 32'h100;
        #1;
        n_cmp++;
        if ({stall, misaligned} !== 2'b00) begin
            n_err++; $display("FAIL reset_with_op: got stall=%b mis=%b, want 0 0", stall, misaligned);
        end
        mem_read = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL idle_no_op: got stall=%b, want 0", stall);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s[5] = '{F3_W, F3_B, F3_BU, F3_HU, F3_H};
        logic [31:0] ads[5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rds[5] = '{32'hDEADBEEF, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000};
        logic [31:0] lds[5] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF};
        obs_t o; exp_t e;
        for (int n = 0; n < 5; n++) begin
            sb.push_back('{addr: {ads[n][31:2], 2'b00}, we: 1'b0, be: 4'hF, wdata: 32'h0,
                           ld: lds[n], err: 1'b0, cycles: 3});
            drive_access(1'b0, f3s[n], ads[n], 32'h0, 0, 0, 1'b1, rds[n], o);
            e = sb.pop_front();
            n_cmp++;
            if ({o.req, o.addr, o.we, o.be} !== {1'b1, e.addr, e.we, e.be}) begin
                n_err++; $display("FAIL load%0d_bus: got req=%b addr=%h we=%b be=%b, want 1 %h %b %b",
                                  n, o.req, o.addr, o.we, o.be, e.addr, e.we, e.be);
            end
            n_cmp++;
            if ({o.done, o.err, o.ld, o.req_done} !== {1'b1, e.err, e.ld, 1'b0}) begin
                n_err++; $display("FAIL load%0d_result: got done=%b err=%b ld=%h req=%b, want 1 %b %h 0",
                                  n, o.done, o.err, o.ld, o.req_done, e.err, e.ld);
            end
            n_cmp++;
            if (o.cycles !== e.cycles || {o.stall0, o.stall_mid} !== 2'b11) begin
                n_err++; $display("FAIL load%0d_timing: got cycles=%0d stall0=%b stallmid=%b, want %0d 1 1",
                                  n, o.cycles, o.stall0, o.stall_mid, e.cycles);
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s[3] = '{F3_H, F3_B, F3_W};
        logic [31:0] ads[3] = '{32'h202, 32'h201, 32'h204};
        logic [3:0]  bes[3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wds[3] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h1234ABCD};
        obs_t o; exp_t e;
        for (int n = 0; n < 3; n++) begin
            sb.push_back('{addr: {ads[n][31:2], 2'b00}, we: 1'b1, be: bes[n], wdata: wds[n],
                           ld: 32'h0, err: 1'b0, cycles: 3});
            drive_access(1'b1, f3s[n], ads[n], 32'h1234ABCD, 0, 0, 1'b1, 32'h55555555, o);
            e = sb.pop_front();
            n_cmp++;
            if ({o.req, o.addr, o.we, o.be, o.wdata} !== {1'b1, e.addr, e.we, e.be, e.wdata}) begin
                n_err++; $display("FAIL store%0d_bus: got addr=%h we=%b be=%b wdata=%h, want %h %b %b %h",
                                  n, o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
            end
            n_cmp++;
            if ({o.done, o.err, o.req_done} !== {1'b1, e.err, 1'b0} || o.cycles !== e.cycles) begin
                n_err++; $display("FAIL store%0d_done: got done=%b err=%b cycles=%0d, want 1 0 %0d",
                                  n, o.done, o.err, o.cycles, e.cycles);
            end
        end
    endtask

    task automatic test_misaligned;
        logic        wes[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s[4] = '{F3_W, F3_H, 3'b100, 3'b011};
        logic [31:0] ads[4] = '{32'h101, 32'h203, 32'h200, 32'h300};
        logic        req_seen;
        for (int n = 0; n < 4; n++) begin
            mem_write = wes[n]; mem_read = !wes[n]; funct3 = f3s[n]; aluresult = ads[n];
            #1;
            n_cmp++;
            if ({misaligned, stall, load_data} !== {1'b1, 1'b0, 32'h0}) begin
                n_err++; $display("FAIL mis%0d_flags: got mis=%b stall=%b ld=%h, want 1 0 0",
                                  n, misaligned, stall, load_data);
            end
            req_seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                req_seen |= dbus_req | stall;
            end
            n_cmp++;
            if (req_seen !== 1'b0) begin
                n_err++; $display("FAIL mis%0d_noreq: got req_or_stall=%b, want 0", n, req_seen);
            end
            mem_read = 1'b0; mem_write = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gnt_delay;
        obs_t o; exp_t e;
        sb.push_back('{addr: 32'h300, we: 1'b1, be: 4'hF, wdata: 32'hCAFEF00D,
                       ld: 32'h0, err: 1'b0, cycles: 6});
        drive_access(1'b1, F3_W, 32'h300, 32'hCAFEF00D, 3, 0, 1'b1, 32'h0, o);
        e = sb.pop_front();
        n_cmp++;
        if ({o.stable, o.addr, o.be, o.wdata} !== {1'b1, e.addr, e.be, e.wdata}) begin
            n_err++; $display("FAIL gnt_hold: got stable=%b addr=%h be=%b wdata=%h, want 1 %h %b %h",
                              o.stable, o.addr, o.be, o.wdata, e.addr, e.be, e.wdata);
        end
        n_cmp++;
        if (o.cycles !== e.cycles || o.stall_mid !== 1'b1 || o.done !== 1'b1) begin
            n_err++; $display("FAIL gnt_timing: got cycles=%0d stallmid=%b done=%b, want %0d 1 1",
                              o.cycles, o.stall_mid, o.done, e.cycles);
        end
        sb.push_back('{addr: 32'h304, we: 1'b0, be: 4'hF, wdata: 32'h0,
                       ld: 32'h00000012, err: 1'b0, cycles: 5});
        drive_access(1'b0, F3_BU, 32'h307, 32'h0, 0, 2, 1'b1, 32'h12345678, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.ld !== e.ld || o.cycles !== e.cycles || o.stall_mid !== 1'b1) begin
            n_err++; $display("FAIL rvalid_delay: got ld=%h cycles=%0d stallmid=%b, want %h %0d 1",
                              o.ld, o.cycles, o.stall_mid, e.ld, e.cycles);
        end
    endtask

    task automatic test_timeout;
        obs_t o; exp_t e;
        // One accept edge plus eight REQ+WAIT cycles before DONE is sampled.
        sb.push_back('{addr: 32'h400, we: 1'b0, be: 4'hF, wdata: 32'h0,
                       ld: 32'h0, err: 1'b1, cycles: 9});
        drive_access(1'b0, F3_W, 32'h400, 32'h0, 0, 0, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_cmp++;
        if ({o.done, o.err, o.ld, o.req_done} !== {1'b1, e.err, e.ld, 1'b0}) begin
            n_err++; $display("FAIL timeout_result: got done=%b err=%b ld=%h req=%b, want 1 1 0 0",
                              o.done, o.err, o.ld, o.req_done);
        end
        n_cmp++;
        if (o.cycles !== e.cycles) begin
            n_err++; $display("FAIL timeout_cycles: got %0d, want %0d", o.cycles, e.cycles);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o; exp_t e;
        mem_read = 1'b1; funct3 = F3_W; aluresult = 32'h500;
        @(posedge clk); #1;
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({stall, misaligned, bus_err, dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, load_data} !== '0) begin
            n_err++; $display("FAIL reset_mid_outputs: got stall=%b req=%b addr=%h be=%b, want all 0",
                              stall, dbus_req, dbus_addr, dbus_be);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        dbus_rvalid = 1'b1; dbus_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        n_cmp++;
        if ({stall, dbus_req, load_data} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL stray_rvalid: got stall=%b req=%b ld=%h, want 0 0 0",
                              stall, dbus_req, load_data);
        end
        sb.push_back('{addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0,
                       ld: 32'h0BADF00D, err: 1'b0, cycles: 3});
        drive_access(1'b0, F3_W, 32'h100, 32'h0, 0, 0, 1'b1, 32'h0BADF00D, o);
        e = sb.pop_front();
        n_cmp++;
        if ({o.addr, o.ld, o.err} !== {e.addr, e.ld, e.err} || o.cycles !== e.cycles) begin
            n_err++; $display("FAIL post_reset_lw: got addr=%h ld=%h err=%b cycles=%0d, want %h %h 0 %0d",
                              o.addr, o.ld, o.err, o.cycles, e.addr, e.ld, e.cycles);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s[5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        logic [2:0]  f3;
        logic [31:0] a, d, rd;
        logic        we;
        int          g, r;
        obs_t o; exp_t e;
        for (int n = 0; n < 12; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = f3s[we ? $urandom_range(0, 2) : $urandom_range(0, 4)];
            a  = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            d  = $urandom; rd = $urandom;
            g  = int'($urandom_range(0, 2)); r = int'($urandom_range(0, 2));
            e.addr = {a[31:2], 2'b00}; e.we = we; e.err = 1'b0; e.cycles = 3 + g + r;
            m_store(f3, a[1:0], d, e.wdata, e.be);
            if (!we) e.be = 4'hF;
            e.ld = we ? 32'h0 : m_load(f3, a[1:0], rd);
            sb.push_back(e);
            drive_access(we, f3, a, d, g, r, 1'b1, rd, o);
            e = sb.pop_front();
            n_cmp++;
            if ({o.addr, o.we, o.be} !== {e.addr, e.we, e.be} || (we && o.wdata !== e.wdata)) begin
                n_err++; $display("FAIL b2b%0d_bus: got addr=%h we=%b be=%b wd=%h, want %h %b %b %h",
                                  n, o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
            end
            n_cmp++;
            if (o.ld !== e.ld || o.err !== 1'b0 || o.cycles !== e.cycles) begin
                n_err++; $display("FAIL b2b%0d_result: f3=%b off=%0d got ld=%h err=%b cyc=%0d, want %h 0 %0d",
                                  n, f3, a[1:0], o.ld, o.err, o.cycles, e.ld, e.cycles);
            end
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_misaligned;
        test_gnt_delay;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
